tdc_edge_decoder: RTL and testbench

Parametrised second-generation TDC back end. It takes the NTDC-bit delay-line snapshot (bit n = DCO level at ref edge + n*dt), removes bubbles and locates the first rising and falling DCO edges. It also builds a calibrated, IIR-tracked estimate of the DCO period in dt units. Sits between the TDC delay line and the DPLL loop filter / phase normaliser, all in the ref_clk domain.

---
 rtl/tdc_pkg.sv | 20 ++
 rtl/tdc_bubble_edge_find.sv | 46 ++++
 rtl/tdc_edge_decoder.sv | 173 +++++++++++++++++
 tb/tb_tdc_edge_decoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC edge decoder.
package tdc_pkg;

    typedef enum logic {StCal, StTrack} tdc_state_e;

    localparam int unsigned NtdcDefault = 64;

    function automatic int unsigned pos_width(input int unsigned ntdc);
        return $clog2(ntdc);
    endfunction

    function automatic int unsigned per_width(input int unsigned pos_w, input int unsigned frac);
        return pos_w + 1 + frac;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tdc_bubble_edge_find.sv
// Combinational bubble filter and first-rise/first-fall priority encoders.
module tdc_bubble_edge_find
    import tdc_pkg::*;
#(
    parameter int unsigned NTDC  = NtdcDefault,
    parameter int unsigned POS_W = pos_width(NTDC)
) (
    input  logic [NTDC-1:0]  raw,
    output logic [NTDC-1:0]  filt,
    input  logic [NTDC-1:0]  m,
    output logic [POS_W-1:0] rise_pos,
    output logic             rise_found,
    output logic [POS_W-1:0] fall_pos,
    output logic             fall_found
);

    // Replicate the end bits so the array edges see a 3-tap window too.
    logic [NTDC+1:0] ext;
    assign ext = {raw[NTDC-1], raw, raw[0]};

    always_comb begin
        filt = '0;
        for (int n = 0; n < NTDC; n++) begin
            filt[n] = maj3(ext[n], ext[n+1], ext[n+2]);
        end
    end

    // Scan downward so the lowest matching index is the last one written.
    always_comb begin
        rise_pos   = '0;
        rise_found = 1'b0;
        fall_pos   = '0;
        fall_found = 1'b0;
        for (int k = NTDC - 1; k >= 1; k--) begin
            if (!m[k-1] && m[k]) begin
                rise_pos   = POS_W'(k);
                rise_found = 1'b1;
            end
            if (m[k-1] && !m[k]) begin
                fall_pos   = POS_W'(k);
                fall_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdc_edge_decoder.sv
// TDC back end: 3-stage edge decode pipeline plus calibrated, IIR-tracked period estimate.
module tdc_edge_decoder
    import tdc_pkg::*;
#(
    parameter int unsigned NTDC      = NtdcDefault,
    parameter int unsigned POS_W     = pos_width(NTDC),
    parameter int unsigned PER_FRAC  = 4,
    parameter int unsigned AVG_LOG2  = 4,
    parameter int unsigned IIR_SHIFT = 3,
    parameter int unsigned PER_W     = per_width(POS_W, PER_FRAC)
) (
    input  logic             ref_clk,
    input  logic             rst_n,
    input  logic             tdc_valid,
    input  logic [NTDC-1:0]  sampled_tdc,
    input  logic             cal_start,
    output logic             out_valid,
    output logic [POS_W-1:0] rise_pos,
    output logic             rise_found,
    output logic [POS_W-1:0] fall_pos,
    output logic             fall_found,
    output logic [PER_W-1:0] period_est,
    output logic             cal_done,
    output logic             outlier
);

    localparam int unsigned PS_W  = POS_W + 1;
    localparam int unsigned ACC_W = PS_W + AVG_LOG2;

    logic [NTDC-1:0]  s1_q, s2_q, filt;
    logic             s1_valid_q, s2_valid_q;
    logic [POS_W-1:0] rise_c, fall_c;
    logic             rise_found_c, fall_found_c;

    logic             out_valid_q, rise_found_q, fall_found_q;
    logic [POS_W-1:0] rise_pos_q, fall_pos_q;

    tdc_bubble_edge_find #(
        .NTDC  (NTDC),
        .POS_W (POS_W)
    ) u_find (
        .raw        (s1_q),
        .filt       (filt),
        .m          (s2_q),
        .rise_pos   (rise_c),
        .rise_found (rise_found_c),
        .fall_pos   (fall_c),
        .fall_found (fall_found_c)
    );

    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            s1_q         <= '0;
            s1_valid_q   <= 1'b0;
            s2_q         <= '0;
            s2_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            rise_pos_q   <= '0;
            rise_found_q <= 1'b0;
            fall_pos_q   <= '0;
            fall_found_q <= 1'b0;
        end else begin
            s1_q        <= sampled_tdc;
            s1_valid_q  <= tdc_valid;
            s2_q        <= filt;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            // Positions hold their last value when the edge is absent.
            if (s2_valid_q) begin
                rise_found_q <= rise_found_c;
                fall_found_q <= fall_found_c;
                if (rise_found_c) rise_pos_q <= rise_c;
                if (fall_found_c) fall_pos_q <= fall_c;
            end
        end
    end

    tdc_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic              outlier_q, outlier_d;

    logic [POS_W-1:0]      pos_diff;
    logic [PS_W-1:0]       ps;
    logic                  ps_valid;
    logic [PER_W-1:0]      sample;
    logic                  in_range;
    logic signed [PER_W:0]   diff, step;
    logic signed [PER_W+1:0] step_ext, sum;
    logic [PER_W-1:0]      tracked;

    assign pos_diff = (rise_pos_q >= fall_pos_q) ? (rise_pos_q - fall_pos_q)
                                                 : (fall_pos_q - rise_pos_q);
    assign ps       = {pos_diff, 1'b0};
    assign ps_valid = out_valid_q & rise_found_q & fall_found_q;
    assign sample   = {ps, {PER_FRAC{1'b0}}};
    assign acc_sum  = acc_q + ACC_W'(ps);

    // p/2 <= S <= 2p, compared as p <= 2S to avoid truncating p/2.
    assign in_range = ({1'b0, period_q} <= {sample, 1'b0}) &&
                      ({1'b0, sample} <= {period_q, 1'b0});

    assign diff     = $signed({1'b0, sample}) - $signed({1'b0, period_q});
    assign step     = diff >>> IIR_SHIFT;
    assign step_ext = {step[PER_W], step};
    assign sum      = $signed({2'b00, period_q}) + step_ext;

    always_comb begin
        tracked = sum[PER_W-1:0];
        if (sum[PER_W+1])  tracked = '0;
        else if (sum[PER_W]) tracked = '1;
    end

    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            state_q   <= StCal;
            acc_q     <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            outlier_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            outlier_q <= outlier_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        outlier_d = 1'b0;
        if (cal_start) begin
            // A sample coinciding with the restart is dropped.
            state_d = StCal;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (ps_valid) begin
            unique case (state_q)
                StCal: begin
                    if (cnt_q == '1) begin
                        period_d = PER_W'({acc_sum, {PER_FRAC{1'b0}}} >> AVG_LOG2);
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StTrack;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StTrack: begin
                    if (in_range) period_d  = tracked;
                    else          outlier_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign rise_pos   = rise_pos_q;
    assign rise_found = rise_found_q;
    assign fall_pos   = fall_pos_q;
    assign fall_found = fall_found_q;
    assign period_est = period_q;
    assign cal_done   = (state_q == StTrack);
    assign outlier    = outlier_q;

endmodule

// File: tb/tb_tdc_edge_decoder.sv
// Directed and randomized checks of tdc_edge_decoder against a cycle-level behavioural model.
module tb_tdc_edge_decoder;

    localparam int NTDC  = 64;
    localparam int POS_W = 6;
    localparam int PER_W = 11;
    localparam int PMAX  = (1 << PER_W) - 1;

    logic              ref_clk = 1'b0;
    logic              rst_n;
    logic              tdc_valid;
    logic [NTDC-1:0]   sampled_tdc;
    logic              cal_start;
    logic              out_valid;
    logic [POS_W-1:0]  rise_pos;
    logic              rise_found;
    logic [POS_W-1:0]  fall_pos;
    logic              fall_found;
    logic [PER_W-1:0]  period_est;
    logic              cal_done;
    logic              outlier;

    tdc_edge_decoder dut (
        .ref_clk     (ref_clk),
        .rst_n       (rst_n),
        .tdc_valid   (tdc_valid),
        .sampled_tdc (sampled_tdc),
        .cal_start   (cal_start),
        .out_valid   (out_valid),
        .rise_pos    (rise_pos),
        .rise_found  (rise_found),
        .fall_pos    (fall_pos),
        .fall_found  (fall_found),
        .period_est  (period_est),
        .cal_done    (cal_done),
        .outlier     (outlier)
    );

    always #5 ref_clk = ~ref_clk;

    int tests = 0;
    int fails = 0;

    // Model state: what the outputs should show after the current edge.
    int m_ov, m_rp, m_rf, m_fp, m_ff, m_p, m_track, m_out;
    logic            h_v [1:2];
    logic [NTDC-1:0] h_d [1:2];
    int              cal_q[$];

    function automatic logic [NTDC-1:0] make_run(input int lo, input int hi);
        logic [NTDC-1:0] s = '0;
        for (int i = lo; i < hi; i++) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [NTDC-1:0] majority(input logic [NTDC-1:0] s);
        logic [NTDC-1:0] m;
        for (int n = 0; n < NTDC; n++) begin
            int a, b, c;
            a = (n == 0) ? s[0] : s[n-1];
            b = s[n];
            c = (n == NTDC - 1) ? s[NTDC-1] : s[n+1];
            m[n] = (a + b + c) >= 2;
        end
        return m;
    endfunction

    task automatic first_edge(input logic [NTDC-1:0] m, input logic want_rise,
                              output int found, output int pos);
        found = 0;
        pos   = 0;
        for (int k = 1; k < NTDC; k++) begin
            if (found == 0 && m[k] == want_rise && m[k-1] == !want_rise) begin
                found = 1;
                pos   = k;
            end
        end
    endtask

    task automatic model_reset();
        m_ov = 0; m_rp = 0; m_rf = 0; m_fp = 0; m_ff = 0;
        m_p = 0; m_track = 0; m_out = 0;
        h_v[1] = 0; h_v[2] = 0; h_d[1] = '0; h_d[2] = '0;
        cal_q.delete();
    endtask

    task automatic model_step(input logic v, input logic [NTDC-1:0] d, input logic c);
        int f, p, ps, s, sum;
        // Period logic consumes the decoded outputs from before this edge.
        m_out = 0;
        if (c) begin
            m_track = 0;
            cal_q.delete();
        end else if (m_ov && m_rf && m_ff) begin
            ps = 2 * ((m_rp > m_fp) ? m_rp - m_fp : m_fp - m_rp);
            if (!m_track) begin
                cal_q.push_back(ps);
                if (cal_q.size() == 16) begin
                    sum = 0;
                    foreach (cal_q[i]) sum += cal_q[i];
                    m_p = (sum * 16) / 16;
                    cal_q.delete();
                    m_track = 1;
                end
            end else begin
                s = ps * 16;
                if (2 * s >= m_p && s <= 2 * m_p) begin
                    m_p = m_p + ((s - m_p) >>> 3);
                    if (m_p > PMAX) m_p = PMAX;
                    if (m_p < 0) m_p = 0;
                end else begin
                    m_out = 1;
                end
            end
        end
        // Edge outputs show the snapshot presented two steps earlier.
        m_ov = h_v[2];
        if (h_v[2]) begin
            first_edge(majority(h_d[2]), 1'b1, f, p);
            m_rf = f;
            if (f != 0) m_rp = p;
            first_edge(majority(h_d[2]), 1'b0, f, p);
            m_ff = f;
            if (f != 0) m_fp = p;
        end
        h_v[2] = h_v[1]; h_d[2] = h_d[1];
        h_v[1] = v;      h_d[1] = d;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("out_valid", out_valid, m_ov);
        check("rise_found", rise_found, m_rf);
        check("fall_found", fall_found, m_ff);
        check("rise_pos", rise_pos, m_rp);
        check("fall_pos", fall_pos, m_fp);
        check("period_est", period_est, m_p);
        check("cal_done", cal_done, m_track);
        check("outlier", outlier, m_out);
    endtask

    task automatic step(input logic v, input logic [NTDC-1:0] d, input logic c);
        rst_n = 1'b1; tdc_valid = v; sampled_tdc = d; cal_start = c;
        @(posedge ref_clk);
        #1;
        model_step(v, d, c);
        check_all();
    endtask

    task automatic reset_step();
        rst_n = 1'b0; tdc_valid = 1'b1; sampled_tdc = {$urandom, $urandom};
        cal_start = 1'($urandom_range(0, 1));
        @(posedge ref_clk);
        #1;
        model_reset();
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, {$urandom, $urandom}, 1'b0);
    endtask

    function automatic logic [NTDC-1:0] rand_snapshot();
        logic [NTDC-1:0] s;
        int a, b;
        if ($urandom_range(0, 3) == 0) return {$urandom, $urandom};
        a = $urandom_range(0, NTDC - 1);
        b = $urandom_range(0, NTDC);
        s = (a < b) ? make_run(a, b) : make_run(b, a);
        if ($urandom_range(0, 1) == 1) s = ~s;
        repeat ($urandom_range(0, 2)) begin
            int idx;
            idx = $urandom_range(0, NTDC - 1);
            s[idx] = ~s[idx];
        end
        return s;
    endfunction

    logic [NTDC-1:0] base, bubbled;

    initial begin
        model_reset();
        base = make_run(10, 30);

        // Reset with random inputs.
        reset_step();
        reset_step();

        // Calibration: 16 samples of ps=40.
        for (int i = 0; i < 16; i++) step(1'b1, base, 1'b0);
        idle(3);
        check("cal_period_640", period_est, 640);
        check("cal_done_set", cal_done, 1);

        // Bubbles at bits 20 and 5 are filtered away.
        bubbled = base;
        bubbled[20] = 1'b0;
        bubbled[5]  = 1'b1;
        step(1'b1, bubbled, 1'b0);
        idle(1);
        check("bubble_rise", rise_pos, 10);
        check("bubble_fall", fall_pos, 30);
        idle(2);

        // All-ones: no edges, positions hold.
        step(1'b1, '1, 1'b0);
        idle(3);
        check("noedge_rise_hold", rise_pos, 10);
        check("noedge_fall_hold", fall_pos, 30);

        // Tracking then outlier.
        step(1'b1, make_run(10, 34), 1'b0);
        idle(3);
        check("track_656", period_est, 656);
        step(1'b1, make_run(10, 60), 1'b0);
        idle(3);
        check("outlier_pulse", outlier, 1);
        check("outlier_hold_656", period_est, 656);
        idle(1);

        // Recalibration with a coincident sample that must be dropped.
        step(1'b1, make_run(10, 34), 1'b0);
        idle(2);
        step(1'b0, '0, 1'b1);
        check("recal_done_clr", cal_done, 0);
        check("recal_hold_656", period_est, 656);
        for (int i = 0; i < 16; i++) step(1'b1, base, 1'b0);
        idle(2);
        check("recal_hold_late", period_est, 656);
        idle(1);
        check("recal_period_640", period_est, 640);

        // Randomized traffic with occasional restarts and a mid-run reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) reset_step();
            else step(1'($urandom_range(0, 3) != 0), rand_snapshot(),
                      1'($urandom_range(0, 80) == 0));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
